// File: rtl/prot_comparator_mc.sv
// Multi-channel protection comparator with hysteresis, debounce and a
// per-channel fault FSM (OK -> PEND -> FAULT -> RETRY -> OK).
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_sample_valid  strobe: i_val holds a new sample for every channel
//   i_val           channel samples, channel k at [k*N +: N]
//   i_ref_high      per-channel trip threshold (val > ref_high is "over")
//   i_ref_low       per-channel release threshold (val < ref_low is "under")
//   i_debounce      consecutive over-samples needed to trip (0 acts as 1)
//   i_retry_time    cycles spent in RETRY before auto release
//   i_latch_mode    1: faults latch until i_clear, 0: auto-retry
//   i_clear         clears sticky bits and releasable latched faults
//   o_fault         per-channel fault (FAULT or RETRY), registered
//   o_fault_any     OR of o_fault, registered alongside it
//   o_sticky        per-channel trip record
module prot_comparator_mc #(
    parameter int unsigned N  = 8,
    parameter int unsigned CH = 4,
    parameter int unsigned DW = 4,
    parameter int unsigned RW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_sample_valid,
    input  logic [CH*N-1:0] i_val,
    input  logic [CH*N-1:0] i_ref_high,
    input  logic [CH*N-1:0] i_ref_low,
    input  logic [DW-1:0]   i_debounce,
    input  logic [RW-1:0]   i_retry_time,
    input  logic            i_latch_mode,
    input  logic            i_clear,
    output logic [CH-1:0]   o_fault,
    output logic            o_fault_any,
    output logic [CH-1:0]   o_sticky
);

    typedef enum logic [1:0] {StOk, StPend, StFault, StRetry} state_e;

    state_e        state_q [CH];
    state_e        state_d [CH];
    logic [DW-1:0] cnt_q   [CH];
    logic [DW-1:0] cnt_d   [CH];
    logic [DW-1:0] cnt_inc [CH];
    logic [RW-1:0] tmr_q   [CH];
    logic [RW-1:0] tmr_d   [CH];

    logic [CH-1:0] over, under;
    logic [CH-1:0] last_under_q, last_under_d;
    logic [CH-1:0] sticky_q, sticky_d;
    logic [CH-1:0] fault_q, fault_d;
    logic          fault_any_q;
    logic [DW-1:0] deb_eff;

    assign deb_eff = (i_debounce == '0) ? DW'(1) : i_debounce;

    // Per-channel unsigned compares; only acted on when i_sample_valid is high.
    always_comb begin
        over  = '0;
        under = '0;
        for (int k = 0; k < CH; k++) begin
            over[k]    = i_val[k*N +: N] > i_ref_high[k*N +: N];
            under[k]   = i_val[k*N +: N] < i_ref_low[k*N +: N];
            cnt_inc[k] = cnt_q[k] + DW'(1);
        end
    end

    always_comb begin
        // Clear first so a same-cycle trip below overrides it.
        sticky_d     = i_clear ? '0 : sticky_q;
        last_under_d = last_under_q;
        fault_d      = '0;
        for (int k = 0; k < CH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            tmr_d[k]   = tmr_q[k];
            if (i_sample_valid) begin
                last_under_d[k] = under[k];
            end
            unique case (state_q[k])
                StOk: begin
                    if (i_sample_valid && over[k]) begin
                        cnt_d[k] = DW'(1);
                        if (deb_eff == DW'(1)) begin
                            state_d[k]  = StFault;
                            sticky_d[k] = 1'b1;
                        end else begin
                            state_d[k] = StPend;
                        end
                    end
                end
                StPend: begin
                    if (i_sample_valid) begin
                        if (over[k]) begin
                            cnt_d[k] = cnt_inc[k];
                            if (cnt_inc[k] == deb_eff) begin
                                state_d[k]  = StFault;
                                sticky_d[k] = 1'b1;
                            end
                        end else begin
                            state_d[k] = StOk;
                            cnt_d[k]   = '0;
                        end
                    end
                end
                StFault: begin
                    // Latched release uses the previously stored under flag.
                    if (i_latch_mode) begin
                        if (i_clear && last_under_q[k]) begin
                            state_d[k] = StOk;
                        end
                    end else if (i_sample_valid && under[k]) begin
                        state_d[k] = StRetry;
                        tmr_d[k]   = '0;
                    end
                end
                StRetry: begin
                    // Re-trip beats timeout; timer saturates instead of wrapping.
                    if (i_sample_valid && over[k]) begin
                        state_d[k] = StFault;
                        tmr_d[k]   = '0;
                    end else if (tmr_q[k] == i_retry_time) begin
                        state_d[k] = StOk;
                    end else if (tmr_q[k] != '1) begin
                        tmr_d[k] = tmr_q[k] + RW'(1);
                    end
                end
            endcase
            fault_d[k] = (state_d[k] == StFault) || (state_d[k] == StRetry);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < CH; k++) begin
                state_q[k] <= StOk;
                cnt_q[k]   <= '0;
                tmr_q[k]   <= '0;
            end
            last_under_q <= '0;
            sticky_q     <= '0;
            fault_q      <= '0;
            fault_any_q  <= 1'b0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                tmr_q[k]   <= tmr_d[k];
            end
            last_under_q <= last_under_d;
            sticky_q     <= sticky_d;
            fault_q      <= fault_d;
            fault_any_q  <= |fault_d;
        end
    end

    assign o_fault     = fault_q;
    assign o_fault_any = fault_any_q;
    assign o_sticky    = sticky_q;

endmodule

// File: tb/tb_prot_comparator_mc.sv
// Bench for prot_comparator_mc: directed scenarios with literal expectations
// plus randomized blocks, all checked every cycle against a behavioural model.
module tb_prot_comparator_mc;

    localparam int N  = 8;
    localparam int CH = 4;
    localparam int DW = 4;
    localparam int RW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid;
    logic [CH*N-1:0] val, hi, lo;
    logic [DW-1:0]   deb;
    logic [RW-1:0]   rtime;
    logic            latch;
    logic            clr;
    logic [CH-1:0]   fault;
    logic            fault_any;
    logic [CH-1:0]   sticky;

    int errors = 0;
    int checks = 0;

    prot_comparator_mc #(.N(N), .CH(CH), .DW(DW), .RW(RW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sample_valid(valid),
        .i_val         (val),
        .i_ref_high    (hi),
        .i_ref_low     (lo),
        .i_debounce    (deb),
        .i_retry_time  (rtime),
        .i_latch_mode  (latch),
        .i_clear       (clr),
        .o_fault       (fault),
        .o_fault_any   (fault_any),
        .o_sticky      (sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_trip    [CH];  // fault output asserted
    bit            m_pending [CH];  // collecting over-samples
    int            m_cnt     [CH];  // over-samples collected so far
    int            m_retry   [CH];  // -1: holding fault; else cycles spent retrying
    bit            m_lu      [CH];
    bit            m_sticky  [CH];
    logic [CH-1:0] exp_fault, exp_sticky;

    task automatic model_step();
        int deff, v, h, l;
        bit ov, un, set;
        deff = (deb == 0) ? 1 : int'(deb);
        for (int k = 0; k < CH; k++) begin
            if (rst) begin
                m_trip[k] = 0; m_pending[k] = 0; m_cnt[k] = 0;
                m_retry[k] = -1; m_lu[k] = 0; m_sticky[k] = 0;
            end else begin
                v = int'(val[k*N +: N]); h = int'(hi[k*N +: N]); l = int'(lo[k*N +: N]);
                ov = valid && (v > h);
                un = valid && (v < l);
                set = 0;
                if (!m_trip[k]) begin
                    if (valid) begin
                        if (ov) begin
                            m_cnt[k] = m_pending[k] ? m_cnt[k] + 1 : 1;
                            m_pending[k] = 1;
                            if (m_cnt[k] == deff) begin
                                m_trip[k] = 1; m_pending[k] = 0; m_retry[k] = -1; set = 1;
                            end
                        end else begin
                            m_pending[k] = 0; m_cnt[k] = 0;
                        end
                    end
                end else if (m_retry[k] < 0) begin
                    if (latch) begin
                        if (clr && m_lu[k]) m_trip[k] = 0;
                    end else if (un) begin
                        m_retry[k] = 0;
                    end
                end else begin
                    if (ov) m_retry[k] = -1;
                    else if (m_retry[k] == int'(rtime)) begin
                        m_trip[k] = 0; m_retry[k] = -1;
                    end else if (m_retry[k] < 65535) m_retry[k]++;
                end
                if (valid) m_lu[k] = (v < l);
                if (clr) m_sticky[k] = 0;
                if (set) m_sticky[k] = 1;
            end
            exp_fault[k]  = m_trip[k];
            exp_sticky[k] = m_sticky[k];
        end
    endtask

    // Single compare process: step the model on each edge, check just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("model_fault", 32'(fault), 32'(exp_fault));
        chk("model_fault_any", 32'(fault_any), 32'(|exp_fault));
        chk("model_sticky", 32'(sticky), 32'(exp_sticky));
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic set_val(input int ch, input int v);
        val[ch*N +: N] = N'(v);
    endtask

    task automatic sample();
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 0; clr = 0; latch = 0; deb = 3; rtime = 5;
        for (int k = 0; k < CH; k++) begin
            hi[k*N +: N] = 8'd100; lo[k*N +: N] = 8'd80; val[k*N +: N] = 8'd90;
        end
        idle(2);
        chk("reset_fault", 32'(fault), 0);
        chk("reset_any", 32'(fault_any), 0);
        chk("reset_sticky", 32'(sticky), 0);
        rst = 1'b0;

        // Debounce trip on ch0
        set_val(0, 101);
        sample(); sample();
        chk("deb_two_samples", 32'(fault), 0);
        sample();
        chk("deb_trip_fault", 32'(fault), 32'h1);
        chk("deb_trip_any", 32'(fault_any), 1);
        chk("deb_trip_sticky", 32'(sticky), 32'h1);

        // Hysteresis band holds, under starts RETRY, release 6 clocks later
        set_val(0, 90); sample();
        chk("band_holds", 32'(fault[0]), 1);
        set_val(0, 79); sample();
        idle(5);
        chk("retry_before_timeout", 32'(fault[0]), 1);
        idle(1);
        chk("retry_released", 32'(fault[0]), 0);

        // Over-sample during RETRY returns to FAULT
        set_val(0, 101); sample(); sample(); sample();
        set_val(0, 79); sample();
        idle(2);
        set_val(0, 101); sample();
        idle(8);
        chk("retry_retrip_holds", 32'(fault[0]), 1);
        set_val(0, 79); sample();
        idle(6);
        chk("retry_release2", 32'(fault[0]), 0);

        // Debounce abort
        set_val(0, 101); sample(); sample();
        set_val(0, 90); sample();
        set_val(0, 101); sample(); sample();
        chk("deb_abort", 32'(fault[0]), 0);
        set_val(0, 90); sample();

        // Latch mode on ch1
        latch = 1;
        set_val(1, 101); sample(); sample(); sample();
        chk("latch_trip", 32'(fault[1]), 1);
        set_val(1, 95); sample();
        pulse_clear();
        chk("latch_clear_in_band", 32'(fault[1]), 1);
        chk("latch_sticky_cleared", 32'(sticky[1]), 0);
        set_val(1, 70); sample();
        pulse_clear();
        chk("latch_clear_release", 32'(fault[1]), 0);
        latch = 0;
        set_val(1, 90);

        // Trip and clear in the same cycle, debounce 0
        deb = 0;
        set_val(2, 101);
        clr = 1'b1; sample(); clr = 1'b0;
        chk("set_beats_clear", 32'(sticky[2]), 1);
        chk("deb0_single_trip", 32'(fault[2]), 1);
        set_val(2, 79); sample(); idle(6);
        set_val(2, 90);

        // Exactly ref_high never trips
        set_val(3, 100); sample(); sample(); sample();
        chk("equal_no_trip", 32'(fault[3]), 0);

        // Reset with ch0 in RETRY and ch3 in PEND
        deb = 3;
        set_val(3, 90);
        set_val(0, 101); sample(); sample(); sample();
        set_val(0, 79); sample();
        set_val(3, 101); sample();
        do_reset();
        chk("midrst_fault", 32'(fault), 0);
        chk("midrst_any", 32'(fault_any), 0);
        chk("midrst_sticky", 32'(sticky), 0);
        sample();
        chk("midrst_no_trip", 32'(fault[3]), 0);

        // Randomized blocks
        for (int b = 0; b < 6; b++) begin
            deb = DW'($urandom_range(0, 4));
            rtime = RW'($urandom_range(0, 7));
            latch = 1'($urandom_range(0, 1));
            for (int k = 0; k < CH; k++) begin
                hi[k*N +: N] = N'($urandom_range(100, 140));
                lo[k*N +: N] = N'($urandom_range(60, 150));
            end
            do_reset();
            for (int c = 0; c < 400; c++) begin
                for (int k = 0; k < CH; k++) set_val(k, int'($urandom_range(50, 180)));
                valid = ($urandom_range(0, 1) == 1);
                clr = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 49) == 0) latch = ~latch;
                @(negedge clk);
            end
            valid = 0; clr = 0;
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
